// File: rtl/exmem_if.sv
// exmem_if -- one EX/MEM entry bus with valid/ready handshake.
//
// The producer of an entry uses the master modport, the consumer uses
// the slave modport. An entry moves when valid && ready at a rising edge.
//   valid   : producer presents an entry
//   ready   : consumer can take the entry
//   busC    : ALU result (DW bits)
//   busB    : store data (DW bits)
//   rd      : destination register index (RW bits)
//   signals : control bundle (SW bits): [SW-1] GPR write, [SW-2] DM write,
//             [0] memory-to-register
//   lw      : entry is a load
interface exmem_if #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int SW = 3
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] busC;
  logic [DW-1:0] busB;
  logic [RW-1:0] rd;
  logic [SW-1:0] signals;
  logic          lw;

  modport master (
    output valid, busC, busB, rd, signals, lw,
    input  ready
  );

  modport slave (
    input  valid, busC, busB, rd, signals, lw,
    output ready
  );

endinterface

// File: rtl/exmem_stage.sv
// exmem_stage -- EX/MEM pipeline stage register of the MIPS32 datapath.
//
// Holds one entry in the main register M, which drives every output, and
// (SKID=1) a second entry in the skid register S so that o_ready can be a
// registered signal. Also provides forwarding / load-use detection against
// the entry held in M and a saturating count of backpressure cycles.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   i_flush      synchronous flush of all held entries (dominates)
//   up           entry bus from EX (slave): valid/ready/busC/busB/rd/signals/lw
//   dn           entry bus to MEM (master); signals and lw read 0 when !valid
//   o_GPRWR      dn.signals[SW-1]
//   o_DMWR       dn.signals[SW-2]
//   o_MTR        dn.signals[0]
//   i_rs, i_rt   source register indices of the instruction now in EX
//   o_fwd_rs     forward dn.busC to rs
//   o_fwd_rt     forward dn.busC to rt
//   o_lu_hazard  held entry is a load that EX depends on; EX must stall
//   i_cnt_clr    synchronous clear of the stall counter (beats increment)
//   o_stall_cnt  saturating count of cycles with dn.valid && !dn.ready
module exmem_stage #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int SW   = 3,
  parameter int SKID = 1,
  parameter int CW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  exmem_if.slave        up,
  exmem_if.master       dn,
  output logic          o_GPRWR,
  output logic          o_DMWR,
  output logic          o_MTR,
  input  logic [RW-1:0] i_rs,
  input  logic [RW-1:0] i_rt,
  output logic          o_fwd_rs,
  output logic          o_fwd_rt,
  output logic          o_lu_hazard,
  input  logic          i_cnt_clr,
  output logic [CW-1:0] o_stall_cnt
);

  typedef struct packed {
    logic [DW-1:0] busc;
    logic [DW-1:0] busb;
    logic [RW-1:0] rd;
    logic [SW-1:0] sig;
    logic          lw;
  } entry_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  entry_t        m_r;
  entry_t        s_r;
  logic          m_valid_r;
  logic          s_valid_r;
  logic [CW-1:0] cnt_r;

  entry_t        in_s;
  logic          ready_s;
  logic          accept_s;
  logic          xfer_s;
  logic          fwd_rs_s;
  logic          fwd_rt_s;

  // Pack the upstream entry.
  assign in_s = '{busc: up.busC, busb: up.busB, rd: up.rd,
                  sig: up.signals, lw: up.lw};

  // With a skid buffer, ready depends only on S, so it comes straight from a
  // flop; without one, a full M can still accept when MEM drains it.
  assign ready_s  = (SKID != 0) ? ~s_valid_r : (~m_valid_r | dn.ready);
  assign accept_s = up.valid & ready_s;
  assign xfer_s   = m_valid_r & dn.ready;

  // Entry storage: M and S registers with their valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_r       <= '0;
      s_r       <= '0;
    end else if (i_flush) begin
      // Data may stay stale, but the control bits are cleared so that the
      // outputs read 0 whenever M is empty.
      m_valid_r <= 1'b0;
      s_valid_r <= 1'b0;
      m_r.sig   <= '0;
      m_r.lw    <= 1'b0;
    end else if (SKID != 0) begin
      if (!m_valid_r || xfer_s) begin
        // M frees up: the older entry in S goes first to keep FIFO order.
        // While S is valid ready is low, so no accept can collide here.
        if (s_valid_r) begin
          m_r       <= s_r;
          m_valid_r <= 1'b1;
          s_valid_r <= 1'b0;
        end else if (accept_s) begin
          m_r       <= in_s;
          m_valid_r <= 1'b1;
        end else begin
          m_valid_r <= 1'b0;
          m_r.sig   <= '0;
          m_r.lw    <= 1'b0;
        end
      end else if (accept_s) begin
        // M is stalled: park the new entry in S (only reachable with S empty).
        s_r       <= in_s;
        s_valid_r <= 1'b1;
      end else begin
        s_valid_r <= s_valid_r;
      end
    end else begin
      s_valid_r <= 1'b0;
      if (accept_s) begin
        m_r       <= in_s;
        m_valid_r <= 1'b1;
      end else if (xfer_s) begin
        m_valid_r <= 1'b0;
        m_r.sig   <= '0;
        m_r.lw    <= 1'b0;
      end else begin
        m_valid_r <= m_valid_r;
      end
    end
  end

  // Saturating backpressure counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (i_cnt_clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (m_valid_r && !dn.ready && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Forwarding looks only at M: S is occupied only while EX is stalled, so
  // the instruction in EX cannot yet depend on it. Register 0 never forwards.
  assign fwd_rs_s = m_valid_r & m_r.sig[SW-1] & (m_r.rd != {RW{1'b0}}) & (m_r.rd == i_rs);
  assign fwd_rt_s = m_valid_r & m_r.sig[SW-1] & (m_r.rd != {RW{1'b0}}) & (m_r.rd == i_rt);

  assign up.ready    = ready_s;
  assign dn.valid    = m_valid_r;
  assign dn.busC     = m_r.busc;
  assign dn.busB     = m_r.busb;
  assign dn.rd       = m_r.rd;
  assign dn.signals  = m_r.sig;
  assign dn.lw       = m_r.lw;
  assign o_GPRWR     = m_r.sig[SW-1];
  assign o_DMWR      = m_r.sig[SW-2];
  assign o_MTR       = m_r.sig[0];
  assign o_fwd_rs    = fwd_rs_s;
  assign o_fwd_rt    = fwd_rt_s;
  assign o_lu_hazard = m_r.lw & (fwd_rs_s | fwd_rt_s);
  assign o_stall_cnt = cnt_r;

endmodule
